// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Imported by imem_fetch_ctrl and pc_next.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } fetch_state_t;

   localparam int unsigned WORD_BYTES = 4;
   localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } if_id_t;

endpackage

// File: rtl/pc_next.sv
// Sequential-PC increment wrapped to memory size,
// plus word alignment of redirect targets.
module pc_next
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 1024
) (
   input  logic [31:0] pc,
   input  logic [31:0] target,
   output logic [31:0] pc_plus4,
   output logic [31:0] target_al
);

   localparam logic [31:0] ADDR_MASK =
      32'(DEPTH * WORD_BYTES) - 32'd1;

   assign pc_plus4  = (pc + 32'(WORD_BYTES)) & ADDR_MASK;
   assign target_al = {target[31:2], 2'b00};

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage controller: boot loader into imem, then
// one fetch per cycle with stall, redirect and halt.
module imem_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH      = 1024,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_valid,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic        load_ready,
   input  logic        load_done,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        imem_we,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic [31:0] if_instr,
   output logic        halted,
   output logic [31:0] fetch_count
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  cnt_q, cnt_d;
   if_id_t       ifid_q, ifid_d;
   logic [31:0]  pc_plus4;
   logic [31:0]  redir_al;
   logic         boot;
   logic         beat;

   pc_next #(
      .DEPTH (DEPTH)
   ) u_pc_next (
      .pc        (pc_q),
      .target    (redirect_pc),
      .pc_plus4  (pc_plus4),
      .target_al (redir_al)
   );

   assign boot       = (state_q == BOOT);
   assign load_ready = boot;
   assign beat       = load_valid & load_ready;

   // Gate by rst_n so no write slips through while reset is held.
   assign imem_we    = beat & rst_n;
   assign imem_addr  = boot ? {load_addr[31:2], 2'b00} : pc_q;
   assign imem_wdata = boot ? load_data : 32'd0;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      ifid_d  = ifid_q;
      unique case (state_q)
         BOOT: begin
            ifid_d.valid = 1'b0;
            if (load_done) begin
               state_d = RUN;
               pc_d    = RESET_PC;
            end
         end
         RUN: begin
            if (redirect_valid) begin
               pc_d         = redir_al;
               ifid_d.valid = 1'b0;
            end else if (!stall) begin
               ifid_d.valid    = 1'b1;
               ifid_d.pc       = pc_q;
               ifid_d.pc_plus4 = pc_plus4;
               ifid_d.instr    = imem_rdata;
               if (cnt_q != 32'hFFFF_FFFF)
                  cnt_d = cnt_q + 32'd1;
               // PC stays on the halt word so imem_addr shows it.
               if (imem_rdata == HALT_INSTR)
                  state_d = HALT;
               else
                  pc_d = pc_plus4;
            end
         end
         HALT: begin
            ifid_d.valid = 1'b0;
            if (redirect_valid) begin
               state_d = RUN;
               pc_d    = redir_al;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         cnt_q   <= 32'd0;
         ifid_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         ifid_q  <= ifid_d;
      end
   end

   assign if_valid    = ifid_q.valid;
   assign if_pc       = ifid_q.pc;
   assign if_pc_plus4 = ifid_q.pc_plus4;
   assign if_instr    = ifid_q.instr;
   assign halted      = (state_q == HALT);
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl with a
// behavioural memory and fetch model.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_valid;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        load_ready;
   logic        load_done;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        imem_we;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic [31:0] if_instr;
   logic        halted;
   logic [31:0] fetch_count;

   always #5 clk = ~clk;

   imem_fetch_ctrl #(
      .DEPTH      (1024),
      .RESET_PC   (32'h0),
      .HALT_INSTR (32'hFFFF_FFFF)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .load_valid     (load_valid),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .load_ready     (load_ready),
      .load_done      (load_done),
      .imem_addr      (imem_addr),
      .imem_wdata     (imem_wdata),
      .imem_we        (imem_we),
      .imem_rdata     (imem_rdata),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4),
      .if_instr       (if_instr),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   logic [31:0] mem [1024];
   logic [31:0] mmem [1024];

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]  = 32'd0;
         mmem[i] = 32'd0;
      end
   end

   always @(posedge clk)
      if (imem_we === 1'b1)
         mem[imem_addr[11:2]] <= imem_wdata;

   assign imem_rdata = mem[imem_addr[11:2]];

   int we_cnt = 0;
   always @(negedge clk)
      if (imem_we === 1'b1)
         we_cnt++;

   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic [31:0] cnt;
      logic        h;
   } exp_t;

   exp_t sbq[$];
   exp_t cur;
   exp_t obs;
   exp_t e;
   int   mstate;
   logic [31:0] mpc;
   int   total = 0;
   int   bad   = 0;

   task automatic drive(input logic st, input logic rv,
                        input logic [31:0] rpc);
      stall          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      if (mstate == 1) begin
         if (rv) begin
            mpc   = {rpc[31:2], 2'b00};
            cur.v = 1'b0;
         end else if (!st) begin
            cur.v     = 1'b1;
            cur.pc    = mpc;
            cur.instr = mmem[mpc[11:2]];
            cur.pc4   = (mpc + 32'd4) % 32'd4096;
            cur.cnt   = cur.cnt + 32'd1;
            if (cur.instr == 32'hFFFF_FFFF)
               mstate = 2;
            else
               mpc = cur.pc4;
         end
      end else if (mstate == 2) begin
         cur.v = 1'b0;
         if (rv) begin
            mpc    = {rpc[31:2], 2'b00};
            mstate = 1;
         end
      end
      cur.h = (mstate == 2);
      sbq.push_back(cur);
      @(posedge clk);
      #1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
   endtask

   task automatic beat(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic dn);
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      load_done  = dn;
      #3;
      total++;
      if (imem_we !== 1'b1 ||
          imem_addr !== {a[31:2], 2'b00}) begin
         bad++;
         $display("FAIL beat a=%h got we=%b addr=%h want 1 %h",
                  a, imem_we, imem_addr, {a[31:2], 2'b00});
      end
      mmem[a[11:2]] = d;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      load_done  = 1'b0;
      if (dn) begin
         mstate = 1;
         mpc    = 32'h0;
      end
   endtask

   logic [31:0] baddr [11] = '{
      32'h0, 32'h4, 32'h8, 32'h6, 32'hC, 32'h10,
      32'h14, 32'h18, 32'h1C, 32'h100, 32'hFFC
   };

   task automatic test_reset();
      rst_n          = 1'b0;
      load_valid     = 1'b1;
      load_addr      = 32'h0;
      load_data      = 32'hDEAD_BEEF;
      load_done      = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      mstate         = 0;
      cur            = '0;
      repeat (3) @(posedge clk);
      #1;
      obs = {if_valid, if_pc, if_pc_plus4, if_instr,
             fetch_count, halted};
      total++;
      if (obs !== '0) begin
         bad++;
         $display("FAIL reset_state got %h want 0", obs);
      end
      total++;
      if (load_ready !== 1'b1 || we_cnt !== 0) begin
         bad++;
         $display("FAIL reset_we got rdy=%b we=%0d want 1 0",
                  load_ready, we_cnt);
      end
      load_valid = 1'b0;
      rst_n      = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_boot_load();
      int w0;
      w0 = we_cnt;
      for (int i = 0; i < 11; i++)
         beat(baddr[i], 32'h1000_0000 + 32'(i * 32'h111),
              i == 10);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (mem[i] !== mmem[i]) begin
            bad++;
            $display("FAIL boot_word%0d got %h want %h",
                     i, mem[i], mmem[i]);
         end
      end
      total++;
      if (we_cnt - w0 !== 11) begin
         bad++;
         $display("FAIL boot_writes got %0d want 11",
                  we_cnt - w0);
      end
   endtask

   task automatic test_stream();
      int w0;
      w0         = we_cnt;
      load_valid = 1'b1;
      load_addr  = 32'h10;
      load_data  = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 32'h0);
         obs = {if_valid, if_pc, if_pc_plus4, if_instr,
                fetch_count, halted};
         e = sbq.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL stream%0d got %h want %h", i, obs, e);
         end
      end
      load_valid = 1'b0;
      total++;
      if (we_cnt !== w0 || fetch_count !== 32'd5) begin
         bad++;
         $display("FAIL stream_cnt got we=%0d cnt=%0d want %0d 5",
                  we_cnt, fetch_count, w0);
      end
   endtask

   task automatic test_stall_redirect();
      for (int i = 0; i < 5; i++) begin
         if (i < 3)
            drive(1'b1, 1'b0, 32'h0);
         else if (i == 3)
            drive(1'b1, 1'b1, 32'h103);
         else
            drive(1'b0, 1'b0, 32'h0);
         obs = {if_valid, if_pc, if_pc_plus4, if_instr,
                fetch_count, halted};
         e = sbq.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL stallred%0d got %h want %h", i, obs, e);
         end
      end
      total++;
      if (if_pc !== 32'h100 || if_valid !== 1'b1) begin
         bad++;
         $display("FAIL redir_target got %h want 100", if_pc);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, i == 0, 32'hFFC);
         obs = {if_valid, if_pc, if_pc_plus4, if_instr,
                fetch_count, halted};
         e = sbq.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL wrap%0d got %h want %h", i, obs, e);
         end
      end
   endtask

   task automatic test_reset_midrun();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 32'h0);
         obs = {if_valid, if_pc, if_pc_plus4, if_instr,
                fetch_count, halted};
         e = sbq.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL prerst%0d got %h want %h", i, obs, e);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      obs = {if_valid, if_pc, if_pc_plus4, if_instr,
             fetch_count, halted};
      total++;
      if (obs !== '0 || load_ready !== 1'b1) begin
         bad++;
         $display("FAIL midrst got %h rdy=%b want 0 1",
                  obs, load_ready);
      end
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mstate = 0;
      cur    = '0;
      sbq.delete();
   endtask

   task automatic test_halt();
      beat(32'hC, 32'hFFFF_FFFF, 1'b0);
      beat(32'h20, 32'h2000_0008, 1'b1);
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, i == 7, 32'h20);
         obs = {if_valid, if_pc, if_pc_plus4, if_instr,
                fetch_count, halted};
         e = sbq.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL halt%0d got %h want %h", i, obs, e);
         end
         if (i == 5) begin
            total++;
            if (imem_addr !== 32'hC) begin
               bad++;
               $display("FAIL halt_addr got %h want c", imem_addr);
            end
         end
      end
      total++;
      if (if_pc !== 32'h20 || if_instr !== 32'h2000_0008) begin
         bad++;
         $display("FAIL resume got %h %h want 20 20000008",
                  if_pc, if_instr);
      end
   endtask

   initial begin
      test_reset();
      test_boot_load();
      test_stream();
      test_stall_redirect();
      test_wrap();
      test_reset_midrun();
      test_halt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
